// File: rtl/scaler_linear_v.sv
// Vertical linear down-scaler: blends each emitted output line from the current input line
// and the previous one held in a single line buffer; 4-clock fixed latency, no backpressure.
module scaler_linear_v #(
    parameter int PIXEL_STEP     = 4096,
    parameter int PIXEL_WIDTH    = 12,
    parameter int COE_WIDTH      = 10,
    parameter int LINE_MAX_WIDTH = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);

    localparam int STEP_LOG2 = $clog2(PIXEL_STEP);
    localparam int FRAC_W    = STEP_LOG2 + 1;
    localparam int COE_SHIFT = STEP_LOG2 - (COE_WIDTH - 1);
    localparam int POS_W     = 24;
    localparam int AW        = (LINE_MAX_WIDTH > 1) ? $clog2(LINE_MAX_WIDTH) : 1;
    localparam int XW        = $clog2(LINE_MAX_WIDTH + 1);
    localparam int PROD_W    = PIXEL_WIDTH + COE_WIDTH;
    localparam int SUM_W     = PROD_W + 1;

    localparam logic [COE_WIDTH-1:0] UNITY   = {1'b1, {(COE_WIDTH-1){1'b0}}};
    localparam logic [POS_W-1:0]     STEP_P  = POS_W'(PIXEL_STEP);
    localparam logic [XW-1:0]        X_LIM   = XW'(LINE_MAX_WIDTH);
    localparam logic [SUM_W-1:0]     ROUND_C = SUM_W'(1) << (COE_WIDTH - 2);
    localparam logic [SUM_W-1:0]     PIX_MAX = SUM_W'({PIXEL_WIDTH{1'b1}});

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    function automatic logic [POS_W-1:0] clamp_step(input logic [15:0] s);
        return (POS_W'(s) < STEP_P) ? STEP_P : POS_W'(s);
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] round_sat(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] r;
        r = (s + ROUND_C) >> (COE_WIDTH - 1);
        return (r > PIX_MAX) ? PIX_MAX[PIXEL_WIDTH-1:0] : r[PIXEL_WIDTH-1:0];
    endfunction

    state_t state_q, state_d;
    logic   run;

    logic                   frame_start, line_start, accept, wr_en, in_range, emit_now;
    logic [POS_W-1:0]       step_r, pos_i_r, pos_o_r;
    logic [POS_W-1:0]       step_eff, pos_i_cur, pos_o_cur, pos_diff;
    logic [FRAC_W-1:0]      frac_r, frac_now;
    logic [XW-1:0]          x_r, x_now;
    logic                   emit_r;
    logic [COE_WIDTH-1:0]   coe1_now, coe0_now;

    logic [PIXEL_WIDTH-1:0] line_buf [LINE_MAX_WIDTH];

    logic [PIXEL_WIDTH-1:0] prev_p0, cur_p0;
    logic [COE_WIDTH-1:0]   coe0_p0, coe1_p0;
    logic [PROD_W-1:0]      prod0_p1, prod1_p1;
    logic [SUM_W-1:0]       sum_p2;
    logic                   vld_p0, vld_p1, vld_p2;
    logic                   hs_p0, hs_p1, hs_p2;
    logic                   vs_p0, vs_p1, vs_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (frame_start) state_d = RUN;
    end

    always_comb begin
        run = 1'b0;
        if (state_q == RUN || frame_start) run = 1'b1;
    end

    assign frame_start = de_i & hs_i & vs_i;
    assign line_start  = de_i & hs_i & run;
    assign accept      = de_i & run;

    // A line start uses freshly computed position state for its own first pixel.
    assign step_eff  = frame_start ? clamp_step(scale_step) : step_r;
    assign pos_i_cur = frame_start ? '0 : pos_i_r;
    assign pos_o_cur = frame_start ? '0 : pos_o_r;
    assign pos_diff  = pos_i_cur - pos_o_cur;
    assign emit_now  = line_start ? (pos_i_cur >= pos_o_cur) : emit_r;
    assign frac_now  = line_start ? FRAC_W'(STEP_P - pos_diff) : frac_r;
    assign x_now     = line_start ? '0 : x_r;
    assign in_range  = (x_now < X_LIM);
    assign wr_en     = accept & in_range;
    assign coe1_now  = COE_WIDTH'(frac_now >> COE_SHIFT);
    assign coe0_now  = UNITY - coe1_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r  <= STEP_P;
            pos_i_r <= '0;
            pos_o_r <= '0;
            x_r     <= '0;
            emit_r  <= 1'b0;
            frac_r  <= '0;
        end else begin
            if (frame_start) step_r <= step_eff;
            if (line_start) begin
                emit_r  <= emit_now;
                frac_r  <= frac_now;
                pos_i_r <= pos_i_cur + STEP_P;
                if (emit_now) pos_o_r <= pos_o_cur + step_eff;
            end
            if (wr_en) x_r <= x_now + XW'(1);
        end
    end

    // Stage p0: read-first line buffer access, capture current pixel and weights
    always_ff @(posedge clk) begin
        if (wr_en) begin
            prev_p0                  <= line_buf[x_now[AW-1:0]];
            line_buf[x_now[AW-1:0]]  <= di_i;
            cur_p0                   <= di_i;
            coe0_p0                  <= coe0_now;
            coe1_p0                  <= coe1_now;
        end
    end

    // Stage p1: weighted products; stage p2: sum
    always_ff @(posedge clk) begin
        prod0_p1 <= PROD_W'(coe0_p0) * PROD_W'(prev_p0);
        prod1_p1 <= PROD_W'(coe1_p0) * PROD_W'(cur_p0);
        sum_p2   <= SUM_W'(prod0_p1) + SUM_W'(prod1_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0;
            hs_p0  <= 1'b0; hs_p1  <= 1'b0; hs_p2  <= 1'b0;
            vs_p0  <= 1'b0; vs_p1  <= 1'b0; vs_p2  <= 1'b0;
        end else begin
            vld_p0 <= wr_en & emit_now;
            hs_p0  <= line_start & emit_now;
            vs_p0  <= frame_start;
            vld_p1 <= vld_p0; hs_p1 <= hs_p0; vs_p1 <= vs_p0;
            vld_p2 <= vld_p1; hs_p2 <= hs_p1; vs_p2 <= vs_p1;
        end
    end

    // Output register: do_o holds its value between valid pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_o <= '0;
            de_o <= 1'b0;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
        end else begin
            de_o <= vld_p2;
            hs_o <= vld_p2 & hs_p2;
            vs_o <= vld_p2 & vs_p2;
            if (vld_p2) do_o <= round_sat(sum_p2);
        end
    end

endmodule

// File: tb/tb_scaler_linear_v.sv
// Directed bench for scaler_linear_v: hand-computed output lines, timing and reset behaviour.
module tb_scaler_linear_v;

    localparam int LMW = 8;
    localparam int PW  = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   scale_step;
    logic [PW-1:0] di_i;
    logic          de_i, hs_i, vs_i;
    logic [PW-1:0] do_o;
    logic          de_o, hs_o, vs_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int q_do[$], q_hs[$], q_vs[$], q_cyc[$];
    int e_do[$], e_hs[$], e_vs[$], e_cyc[$];

    scaler_linear_v #(.LINE_MAX_WIDTH(LMW)) dut (
        .clk(clk), .rst_n(rst_n), .scale_step(scale_step),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (de_o) begin
            q_do.push_back(int'(do_o));
            q_hs.push_back(int'(hs_o));
            q_vs.push_back(int'(vs_o));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put(input int d, input bit h, input bit v, input bit e);
        @(posedge clk);
        #1;
        di_i = PW'(d);
        hs_i = h;
        vs_i = v;
        de_i = e;
    endtask

    // Pixel x of a line is base+mult*x; if emitted, expected output is ebase+emult*x.
    task automatic line(input int base, input int mult, input int n, input bit v,
                        input bit emit, input int ebase, input int emult, input int gap_at);
        for (int x = 0; x < n; x++) begin
            if (x == gap_at) begin
                put(0, 0, 0, 0);
                put(0, 0, 0, 0);
            end
            put(base + mult * x, x == 0, v && (x == 0), 1'b1);
            if (emit && x < LMW) begin
                e_do.push_back(ebase + emult * x);
                e_hs.push_back(int'(x == 0));
                e_vs.push_back(int'(v && (x == 0)));
                e_cyc.push_back(cyc + 4);
            end
        end
        repeat (3) put(0, 0, 0, 0);
    endtask

    task automatic clear_q();
        q_do.delete(); q_hs.delete(); q_vs.delete(); q_cyc.delete();
        e_do.delete(); e_hs.delete(); e_vs.delete(); e_cyc.delete();
    endtask

    task automatic verify(input string name);
        repeat (8) put(0, 0, 0, 0);
        chk({name, " count"}, q_do.size(), e_do.size());
        for (int i = 0; i < e_do.size() && i < q_do.size(); i++) begin
            chk($sformatf("%s do[%0d]", name, i), q_do[i], e_do[i]);
            chk($sformatf("%s hs[%0d]", name, i), q_hs[i], e_hs[i]);
            chk($sformatf("%s vs[%0d]", name, i), q_vs[i], e_vs[i]);
            chk($sformatf("%s cyc[%0d]", name, i), q_cyc[i], e_cyc[i]);
        end
        clear_q();
    endtask

    initial begin
        int  e2[6];
        bit  m2[6];
        int  e7[6];
        bit  m7[6];
        e2 = '{0, 0, 150, 300, 0, 450};
        m2 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        e7 = '{0, 0, 125, 250, 375, 500};
        m7 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; scale_step = 16'd4096;
        di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset do_o", int'(do_o), 0);
        chk("reset de_o", int'(de_o), 0);
        chk("reset hs_o", int'(hs_o), 0);
        chk("reset vs_o", int'(vs_o), 0);
        rst_n = 1'b1;

        // No frame start yet: a line with hs only must be ignored
        line(5, 1, 5, 1'b0, 1'b0, 0, 0, -1);
        verify("idle");

        // Unity step pass-through, with a de gap inside line 1
        scale_step = 16'd4096;
        for (int l = 0; l < 4; l++)
            line(100 * l, 1, 5, l == 0, 1'b1, 100 * l, 1, (l == 1) ? 2 : -1);
        verify("s1 step1.0");

        scale_step = 16'd6144;
        for (int l = 0; l < 6; l++)
            line(100 * l, 0, 5, l == 0, m2[l], e2[l], 0, -1);
        verify("s2 step1.5");

        scale_step = 16'd8192;
        for (int l = 0; l < 5; l++)
            line(100 * l + 3, 1, 5, l == 0, (l % 2) == 0, 100 * l + 3, 1, -1);
        verify("s3 step2.0");

        scale_step = 16'd1000;
        for (int l = 0; l < 4; l++)
            line(100 * l + 7, 1, 5, l == 0, 1'b1, 100 * l + 7, 1, -1);
        verify("s4 clamp");

        // Over-long lines: only 8 pixels kept; odd line1 sum checks rounding
        scale_step = 16'd6144;
        line(0,   10, 10, 1'b1, 1'b1, 0,   10, -1);
        line(101, 10, 10, 1'b0, 1'b0, 0,   0,  -1);
        line(200, 10, 10, 1'b0, 1'b1, 151, 10, -1);
        verify("s5 overlong");

        // Step 1.25: weights 1/4, 1/2, 3/4 of the current line
        scale_step = 16'd5120;
        for (int l = 0; l < 6; l++)
            line(100 * l, 0, 3, l == 0, m7[l], e7[l], 0, -1);
        verify("s7 step1.25");

        // Reset in the middle of an output line
        scale_step = 16'd4096;
        for (int x = 0; x < 7; x++)
            put(500 + x, x == 0, x == 0, 1'b1);
        #2;
        chk("pre-reset de_o", int'(de_o), 1);
        chk("pre-reset do_o", int'(do_o), 502);
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid-reset do_o", int'(do_o), 0);
        chk("mid-reset de_o", int'(de_o), 0);
        chk("mid-reset hs_o", int'(hs_o), 0);
        chk("mid-reset vs_o", int'(vs_o), 0);
        repeat (3) put(0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) put(0, 0, 0, 0);
        clear_q();
        line(600, 1, 5, 1'b0, 1'b0, 0, 0, -1);
        line(650, 1, 5, 1'b0, 1'b0, 0, 0, -1);
        verify("s6 no vs");
        line(700, 1, 5, 1'b1, 1'b1, 700, 1, -1);
        line(800, 1, 5, 1'b0, 1'b1, 800, 1, -1);
        verify("s6 new frame");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
